// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and buffers
// {pc, ins} pairs in a small FIFO consumed by decode through valid/ready.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_misalign;
  logic [31:0]   r_mem_pc  [DEPTH];
  logic [31:0]   r_mem_ins [DEPTH];

  logic w_pop;
  logic w_push;

  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid & out_ready;
  // A full FIFO can still accept a fetch when its head leaves in the same cycle.
  assign w_push       = ~redirect_valid & ((r_count < CW'(DEPTH)) | w_pop);

  assign imem_addr    = r_pc;
  assign out_ins      = r_mem_ins[r_rptr];
  assign out_pc       = r_mem_pc[r_rptr];
  assign misalign_err = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]  <= '0;
        r_mem_ins[i] <= '0;
      end
    end else begin
      r_misalign <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid) begin
        // Flush wins over any push/pop; a coincident pop was still handshaken by decode.
        r_pc    <= {redirect_pc[31:2], 2'b00};
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem_pc[r_wptr]  <= r_pc;
          r_mem_ins[r_wptr] <= imem_ins;
          r_wptr            <= r_wptr + AW'(1);
          r_pc              <= r_pc + 32'd4;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage for the RV32E core. Owns the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction together with its PC into a small FIFO. Decode consumes the FIFO through a valid/ready handshake. Execute redirects the stage on taken branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DEPTH, 2: entries in the fetch FIFO. Must be a power of two and at least 2.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to the instruction ROM; equals the PC register.
- imem_ins  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  one-cycle request to change the PC.
- redirect_pc  in  32  redirect target; sampled when redirect_valid=1.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_ins  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of the head instruction.
- misalign_err  out  1  registered one-cycle pulse; the last redirect_pc had bits [1:0] != 0.

## Operation
- State:
  - pc register (32 bits).
  - FIFO of DEPTH entries of {pc, ins}, with read/write pointers and an occupancy counter of width log2(DEPTH)+1.
  - misalign_err flop.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop). This allows push and pop in the same cycle when the FIFO is full.
- On push: write {pc, imem_ins} at the write pointer, advance the write pointer, and set pc <= pc + 4.
  - The PC add is 32-bit and wraps modulo 2^32, so 0xFFFF_FFFC + 4 = 0x0000_0000.
- On pop: advance the read pointer. Pointers wrap modulo DEPTH.
- count updates by +1 (push only), -1 (pop only), or unchanged (both or neither).
- Redirect has priority over everything:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - The FIFO is flushed: pointers and count go to 0.
  - There is no push that cycle.
  - misalign_err <= |redirect_pc[1:0]. Otherwise misalign_err <= 0.
- A pop coinciding with redirect_valid still completes as a handshake. Decode owns the decision to discard it.
- out_ins and out_pc come from the FIFO head. Their value is don't-care when out_valid=0.
- The stage has no state machine beyond the FIFO occupancy: states empty, partial and full are implied by count.

## Timing
- Reset (asynchronous, takes effect immediately): pc=RESET_PC, imem_addr=RESET_PC, count=0, out_valid=0, misalign_err=0. out_ins and out_pc read as 0 (FIFO storage is cleared).
- Fetch latency: the PC presented in cycle N appears at the FIFO head no earlier than cycle N+1.
  - The first out_valid=1 is in the first cycle after the first rising edge following reset release.
- Steady state: with out_ready held at 1, one instruction is delivered per cycle at consecutive PCs with no bubbles.
- Backpressure: with out_ready=0, the FIFO fills in DEPTH cycles. The PC then holds and imem_addr is stable until a pop.
- Redirect in cycle N:
  - out_valid=0 in cycle N+1.
  - imem_addr = target in cycle N+1.
  - The target instruction is at the head in cycle N+2.
- Back-to-back redirects: each one flushes the FIFO, and the last one wins.
- A redirect arriving while the FIFO is full and out_ready=0 is still taken immediately.
- The outputs out_valid, out_ins and out_pc are registered. imem_addr is registered (it is the PC register).

## Test plan
- Reset and stream: release rst_n with RESET_PC=0 and out_ready=1 on the standard ROM image.
  - Required: consecutive outputs (pc, ins) are (0x00, 0x00000013), (0x04, 0x00500193), (0x08, 0x00318233), one per cycle.
- Backpressure:
  - Hold out_ready=0 for 5 cycles. Required: count saturates at 2, imem_addr holds at 0x08, out_pc stays 0x00.
  - Then raise out_ready. Required: the sequence continues 0x00, 0x04, 0x08 with no drop or duplicate.
- Redirect mid-stream: assert redirect_valid with redirect_pc=0x20 while the FIFO holds 2 entries.
  - Required: out_valid=0 next cycle, then out_pc=0x20 with out_ins=0x00748663, followed by 0x24 with 0x00527313.
- Misaligned redirect: redirect_pc=0x2E.
  - Required: misalign_err pulses for exactly 1 cycle, and the next head is pc=0x2C with ins=0x00010597.
- Simultaneous pop and redirect: FIFO full, out_ready=1, redirect to 0x34.
  - Required: the head at 0x00 is handshaken in that cycle, then out_pc=0x34 follows after one bubble.
- Asynchronous reset mid-stream: drop rst_n between clock edges.
  - Required: outputs go to their reset values immediately without waiting for a clock edge. After release, the stream restarts at 0x00.
